// File: rtl/vga_fetch_pkg.sv
// vga_fetch_pkg
// Shared constants and types for the note/fret table fetcher.
// Holds the RAM location and size of the note table, the lane geometry
// defaults, the visible-line limit, the fetch state enum, the packed
// table-entry layout and a helper that flags parked entries.
package vga_fetch_pkg;

  // Note table location in the shared RAM (word address) and entry count.
  localparam logic [15:0] BASE_ADDR = 16'hF000;
  localparam int          NUM_NOTES = 20;

  // Lane geometry, in pixels.
  localparam int LANE_X0 = 160;
  localparam int LANE_W  = 64;
  localparam int NOTE_W  = 56;
  localparam int NOTE_H  = 16;

  // Visible lines and highest legal lane number.
  localparam int VIS_LINES = 480;
  localparam int MAX_LANE  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [3:0]  lane;
    logic [11:0] y;
  } note_entry_t;

  // Value every entry takes after reset: off-screen, so it can never hit.
  localparam note_entry_t PARKED_ENTRY = '{lane: 4'h0, y: 12'hFFF};

  // An entry below the visible area or on a non-existent lane never hits.
  function automatic logic entry_parked(input note_entry_t e);
    return (e.y >= 12'(VIS_LINES)) || (e.lane > 4'(MAX_LANE));
  endfunction

endpackage

// File: rtl/note_hit_cmp.sv
// note_hit_cmp
// Combinational test of one note-table entry against the scan position.
// Ports:
//   i_entry  [15:0] packed note entry {lane[3:0], y[11:0]}
//   i_hcount [9:0]  current pixel x
//   i_vcount [9:0]  current pixel y
//   o_hit           pixel lies inside this entry's note rectangle
module note_hit_cmp
  import vga_fetch_pkg::*;
(
  input  logic [15:0] i_entry,
  input  logic [9:0]  i_hcount,
  input  logic [9:0]  i_vcount,
  output logic        o_hit
);

  note_entry_t w_entry;
  logic [11:0] w_h;
  logic [11:0] w_v;
  logic [11:0] w_x_lo;
  logic [11:0] w_x_hi;
  logic [12:0] w_y_hi;

  assign w_entry = note_entry_t'(i_entry);
  assign w_h     = {2'b00, i_hcount};
  assign w_v     = {2'b00, i_vcount};

  // Horizontal extent of the note; 12 bits covers every 4-bit lane value.
  assign w_x_lo = 12'(LANE_X0) + ({8'h00, w_entry.lane} * 12'(LANE_W));
  assign w_x_hi = w_x_lo + 12'(NOTE_W - 1);

  // Bottom edge kept at 13 bits so y near 12'hFFF cannot wrap into range.
  assign w_y_hi = {1'b0, w_entry.y} + 13'(NOTE_H - 1);

  assign o_hit = !entry_parked(w_entry)
              && (w_h >= w_x_lo) && (w_h <= w_x_hi)
              && ({1'b0, w_v} >= {1'b0, w_entry.y})
              && ({1'b0, w_v} <= w_y_hi);

endmodule

// File: rtl/note_table_fetch.sv
// note_table_fetch
// Once per frame, on frame_start, reads NUM_NOTES words starting at
// BASE_ADDR from RAM port B into a local note table, then flags every
// pixel that falls inside a note and reports its lane.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   frame_start         one-cycle pulse at start of vertical blank
//   hcount, vcount      current scan position
//   addr_B/en_B/data_B  RAM port B request (read-only: en_B, data_B = 0)
//   out_B               RAM port B read data, one cycle after addr_B
//   busy                fetch in progress (FETCH or DRAIN)
//   table_valid         a complete fetch has finished since reset
//   pixel_note          registered: current pixel lies inside a note
//   pixel_lane          registered: lane of the lowest-index hitting entry
// Configuration macro FETCH_DBLBUF_EN: when defined, words land in a
// shadow table that is copied to the active table in one clock as DRAIN
// exits, so the hit outputs never see a partially fetched table.
module note_table_fetch
  import vga_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_B,
  output logic        en_B,
  output logic [15:0] data_B,
  input  logic [15:0] out_B,
  output logic        busy,
  output logic        table_valid,
  output logic        pixel_note,
  output logic [3:0]  pixel_lane
);

  localparam int              IDX_W    = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

  fetch_state_e     r_state;
  fetch_state_e     w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_drain_exit;

  note_entry_t      r_active [NUM_NOTES];
  logic             r_valid;
  logic             r_pixel_note;
  logic [3:0]       r_pixel_lane;

  logic [NUM_NOTES-1:0] w_hit;
  logic                 w_any;
  logic [3:0]           w_lane;

  // Fetch state and address index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; also decides which entry captures out_B this cycle.
  // out_B lags addr_B by one cycle, so the word written while address i is
  // on the bus belongs to entry i-1, and DRAIN picks up the last one.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_idx - 7'd1;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_state_nxt = FETCH;
          w_idx_nxt   = '0;
        end else begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end
      end
      FETCH: begin
        w_wr_en = (r_idx != 7'd0);
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DRAIN;
          w_idx_nxt   = r_idx;
        end else begin
          w_state_nxt = FETCH;
          w_idx_nxt   = r_idx + 7'd1;
        end
      end
      DRAIN: begin
        w_wr_en     = 1'b1;
        w_wr_idx    = LAST_IDX;
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_drain_exit = (r_state == DRAIN);

`ifdef FETCH_DBLBUF_EN
  note_entry_t r_shadow [NUM_NOTES];

  // Shadow table fills during the fetch; the whole table moves to the
  // active copy as DRAIN exits, with the final word bypassed straight in.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        r_shadow[k] <= PARKED_ENTRY;
        r_active[k] <= PARKED_ENTRY;
      end
    end else begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        if (w_wr_en && (w_wr_idx == IDX_W'(k))) begin
          r_shadow[k] <= note_entry_t'(out_B);
        end
        if (w_drain_exit) begin
          r_active[k] <= (w_wr_en && (w_wr_idx == IDX_W'(k)))
                         ? note_entry_t'(out_B) : r_shadow[k];
        end
      end
    end
  end
`else
  // Fetched words go straight into the active table, lowest index first.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        r_active[k] <= PARKED_ENTRY;
      end
    end else begin
      for (int k = 0; k < NUM_NOTES; k++) begin
        if (w_wr_en && (w_wr_idx == IDX_W'(k))) begin
          r_active[k] <= note_entry_t'(out_B);
        end
      end
    end
  end
`endif

  // table_valid latches once the first fetch completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (w_drain_exit) begin
      r_valid <= 1'b1;
    end else begin
      r_valid <= r_valid;
    end
  end

  // One comparator per table entry.
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_cmp
    note_hit_cmp u_cmp (
      .i_entry  (r_active[g]),
      .i_hcount (hcount),
      .i_vcount (vcount),
      .o_hit    (w_hit[g])
    );
  end

  // Priority encoder: scanning from the top down leaves the lowest hitting
  // index in control of the lane.
  always_comb begin
    w_any  = 1'b0;
    w_lane = 4'h0;
    for (int k = NUM_NOTES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any  = 1'b1;
        w_lane = r_active[k].lane;
      end else begin
        w_any  = w_any;
        w_lane = w_lane;
      end
    end
  end

  // Registered pixel outputs, one cycle behind hcount/vcount.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_note <= 1'b0;
      r_pixel_lane <= 4'h0;
    end else begin
      r_pixel_note <= w_any;
      r_pixel_lane <= w_lane;
    end
  end

  assign addr_B      = (r_state == FETCH) ? (BASE_ADDR + {9'h000, r_idx}) : BASE_ADDR;
  assign en_B        = 1'b0;
  assign data_B      = 16'h0000;
  assign busy        = (r_state != IDLE);
  assign table_valid = r_valid;
  assign pixel_note  = r_pixel_note;
  assign pixel_lane  = r_pixel_lane;

endmodule
